// File: rtl/video_mnist_cnn_pkg.sv
// Package for the MNIST CNN argmax stage.
// Holds the default class/vote geometry, the derived index and count widths
// and the matching typedefs shared by the design and its bench.
package video_mnist_cnn_pkg;

  localparam int NUM_CLASS   = 10;
  localparam int VOTE_NUM    = 8;
  // 2^CLASS_WIDTH >= NUM_CLASS and 2^COUNT_WIDTH > VOTE_NUM must hold.
  localparam int CLASS_WIDTH = 4;
  localparam int COUNT_WIDTH = 4;

  typedef logic [CLASS_WIDTH-1:0] class_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/video_mnist_cnn_popcount.sv
// Registered popcount of one class's vote group.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   cke_i         pipeline enable; the count register only loads when high
//   votes_i       VOTE_NUM binary votes of one class
//   count_o       number of set votes (0..VOTE_NUM), one cycle later
module video_mnist_cnn_popcount #(
  parameter int VOTE_NUM    = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cke_i,
  input  logic [VOTE_NUM-1:0]    votes_i,
  output logic [COUNT_WIDTH-1:0] count_o
);

  logic [COUNT_WIDTH-1:0] count_d;
  logic [COUNT_WIDTH-1:0] count_q;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < VOTE_NUM; i++) begin
      count_d = count_d + COUNT_WIDTH'(votes_i[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (cke_i) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/video_mnist_cnn_argmax.sv
// Argmax stage behind the MNIST CNN core: per-class popcount, argmax over
// classes and a threshold test, as a three-stage stall-together pipeline.
// Ports:
//   reset, clk                 asynchronous active-high reset, clock
//   param_th                   detect threshold on the winning count
//   s_axi4s_*                  vote stream in (tuser[0] = frame start)
//   m_axi4s_*                  class / count / detect stream out
//   stat_detect_count          detected pixels in the last complete frame
// Handshake: a beat moves when tvalid & tready are both high on a rising
// clk; the producer holds its beat stable until then. s_axi4s_tready only
// depends on the output register's valid and m_axi4s_tready.
// Optional feature macro: VIDEO_MNIST_CNN_ARGMAX_STAT_EN enables the
// per-frame detect counter; without it stat_detect_count is tied to 0.
module video_mnist_cnn_argmax #(
  parameter int TUSER_WIDTH   = 1,
  parameter int NUM_CLASS     = video_mnist_cnn_pkg::NUM_CLASS,
  parameter int VOTE_NUM      = video_mnist_cnn_pkg::VOTE_NUM,
  parameter int S_TDATA_WIDTH = NUM_CLASS * VOTE_NUM,
  parameter int CLASS_WIDTH   = video_mnist_cnn_pkg::CLASS_WIDTH,
  parameter int COUNT_WIDTH   = video_mnist_cnn_pkg::COUNT_WIDTH,
  parameter int STAT_WIDTH    = 20
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [COUNT_WIDTH-1:0]   param_th,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tdetect,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [STAT_WIDTH-1:0]    stat_detect_count
);

  // Every stage advances together whenever the output slot can move.
  logic cke;
  assign cke            = ~m_axi4s_tvalid | m_axi4s_tready;
  assign s_axi4s_tready = cke;

  // Stage 1: per-class counts (in the popcount instances) plus sideband.
  logic [COUNT_WIDTH-1:0] cnt1 [NUM_CLASS];
  logic                   st1_valid_q;
  logic [TUSER_WIDTH-1:0] st1_tuser_q;
  logic                   st1_tlast_q;

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_pop
    video_mnist_cnn_popcount #(
      .VOTE_NUM    (VOTE_NUM),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_pop (
      .clk_i   (clk),
      .rst_i   (reset),
      .cke_i   (cke),
      .votes_i (s_axi4s_tdata[g*VOTE_NUM +: VOTE_NUM]),
      .count_o (cnt1[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_valid_q <= 1'b0;
      st1_tuser_q <= '0;
      st1_tlast_q <= 1'b0;
    end else if (cke) begin
      st1_valid_q <= s_axi4s_tvalid;
      st1_tuser_q <= s_axi4s_tuser;
      st1_tlast_q <= s_axi4s_tlast;
    end
  end

  // Stage 2: argmax. Strictly-greater keeps the lowest index on ties and
  // leaves class 0 / count 0 when every count is zero.
  logic [CLASS_WIDTH-1:0] best_cls_d;
  logic [COUNT_WIDTH-1:0] best_cnt_d;

  always_comb begin
    best_cls_d = '0;
    best_cnt_d = cnt1[0];
    for (int c = 1; c < NUM_CLASS; c++) begin
      if (cnt1[c] > best_cnt_d) begin
        best_cnt_d = cnt1[c];
        best_cls_d = CLASS_WIDTH'(c);
      end
    end
  end

  logic                   st2_valid_q;
  logic [TUSER_WIDTH-1:0] st2_tuser_q;
  logic                   st2_tlast_q;
  logic [CLASS_WIDTH-1:0] st2_cls_q;
  logic [COUNT_WIDTH-1:0] st2_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st2_valid_q <= 1'b0;
      st2_tuser_q <= '0;
      st2_tlast_q <= 1'b0;
      st2_cls_q   <= '0;
      st2_cnt_q   <= '0;
    end else if (cke) begin
      st2_valid_q <= st1_valid_q;
      st2_tuser_q <= st1_tuser_q;
      st2_tlast_q <= st1_tlast_q;
      st2_cls_q   <= best_cls_d;
      st2_cnt_q   <= best_cnt_d;
    end
  end

  // Stage 3: output register; param_th is sampled here.
  logic                   m_valid_q;
  logic [TUSER_WIDTH-1:0] m_tuser_q;
  logic                   m_tlast_q;
  logic [CLASS_WIDTH-1:0] m_cls_q;
  logic [COUNT_WIDTH-1:0] m_cnt_q;
  logic                   m_det_q;
  logic                   det_d;

  assign det_d = (st2_cnt_q >= param_th);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_tuser_q <= '0;
      m_tlast_q <= 1'b0;
      m_cls_q   <= '0;
      m_cnt_q   <= '0;
      m_det_q   <= 1'b0;
    end else if (cke) begin
      m_valid_q <= st2_valid_q;
      m_tuser_q <= st2_tuser_q;
      m_tlast_q <= st2_tlast_q;
      m_cls_q   <= st2_cls_q;
      m_cnt_q   <= st2_cnt_q;
      m_det_q   <= det_d;
    end
  end

  assign m_axi4s_tvalid  = m_valid_q;
  assign m_axi4s_tuser   = m_tuser_q;
  assign m_axi4s_tlast   = m_tlast_q;
  assign m_axi4s_tclass  = m_cls_q;
  assign m_axi4s_tcount  = m_cnt_q;
  assign m_axi4s_tdetect = m_det_q;

`ifdef VIDEO_MNIST_CNN_ARGMAX_STAT_EN
  // Detect accumulator over output handshakes. A frame-start handshake
  // publishes the previous frame's total and restarts counting with that
  // pixel's own detect bit.
  logic                  out_hs;
  logic [STAT_WIDTH-1:0] acc_d;
  logic [STAT_WIDTH-1:0] acc_q;
  logic [STAT_WIDTH-1:0] stat_d;
  logic [STAT_WIDTH-1:0] stat_q;

  assign out_hs = m_valid_q & m_axi4s_tready;

  always_comb begin
    acc_d  = acc_q;
    stat_d = stat_q;
    if (out_hs) begin
      if (m_tuser_q[0]) begin
        stat_d = acc_q;
        acc_d  = m_det_q ? STAT_WIDTH'(1) : '0;
      end else if (m_det_q && (acc_q != '1)) begin
        acc_d = acc_q + STAT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      stat_q <= '0;
    end else begin
      acc_q  <= acc_d;
      stat_q <= stat_d;
    end
  end

  assign stat_detect_count = stat_q;
`else
  assign stat_detect_count = '0;
`endif

endmodule

// File: tb/tb_video_mnist_cnn_argmax.sv
// Self-checking bench for video_mnist_cnn_argmax: a scoreboard queue is
// filled at input accept from a behavioural model and drained by a monitor
// on every output handshake; the monitor also checks output stability
// while the sink stalls.
module tb_video_mnist_cnn_argmax;
  import video_mnist_cnn_pkg::*;

  localparam int SW  = NUM_CLASS * VOTE_NUM;
  localparam int STW = 20;
  localparam int OW  = 2 + CLASS_WIDTH + COUNT_WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [COUNT_WIDTH-1:0] param_th;
  logic                   s_tuser;
  logic                   s_tlast;
  logic [SW-1:0]          s_tdata;
  logic                   s_tvalid;
  logic                   s_tready;
  logic                   m_tuser;
  logic                   m_tlast;
  class_t                 m_tclass;
  count_t                 m_tcount;
  logic                   m_tdetect;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [STW-1:0]         stat;

  video_mnist_cnn_argmax dut (
    .reset             (reset),
    .clk               (clk),
    .param_th          (param_th),
    .s_axi4s_tuser     (s_tuser),
    .s_axi4s_tlast     (s_tlast),
    .s_axi4s_tdata     (s_tdata),
    .s_axi4s_tvalid    (s_tvalid),
    .s_axi4s_tready    (s_tready),
    .m_axi4s_tuser     (m_tuser),
    .m_axi4s_tlast     (m_tlast),
    .m_axi4s_tclass    (m_tclass),
    .m_axi4s_tcount    (m_tcount),
    .m_axi4s_tdetect   (m_tdetect),
    .m_axi4s_tvalid    (m_tvalid),
    .m_axi4s_tready    (m_tready),
    .stat_detect_count (stat)
  );

  // ---------------- scoreboard state ----------------
  int             n_tests = 0;
  int             n_fail  = 0;
  int             n_out   = 0;
  bit             rand_ready = 1'b0;
  logic [OW-1:0]  exp_q[$];
  logic [OW-1:0]  mon_prev;
  logic [OW-1:0]  mon_cur;
  bit             mon_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: count votes per class, keep the first class reaching the
  // highest count, compare against the threshold.
  function automatic logic [OW-1:0] model(input logic [SW-1:0] d, input logic tu,
                                          input logic tl, input logic [COUNT_WIDTH-1:0] th);
    int best_c;
    int best_n;
    int n;
    best_c = 0;
    best_n = -1;
    for (int c = 0; c < NUM_CLASS; c++) begin
      n = 0;
      for (int v = 0; v < VOTE_NUM; v++) n += int'(d[c*VOTE_NUM + v]);
      if (n > best_n) begin
        best_n = n;
        best_c = c;
      end
    end
    return {tu, tl, CLASS_WIDTH'(best_c), COUNT_WIDTH'(best_n), (best_n >= int'(th))};
  endfunction

  function automatic logic [SW-1:0] votes2(input int c0, input logic [7:0] v0,
                                           input int c1, input logic [7:0] v1);
    logic [SW-1:0] d;
    d = '0;
    d[c0*VOTE_NUM +: VOTE_NUM] = v0;
    d[c1*VOTE_NUM +: VOTE_NUM] = v1;
    return d;
  endfunction

  function automatic logic [SW-1:0] rand_votes();
    logic [SW-1:0] d;
    for (int c = 0; c < NUM_CLASS; c++) d[c*VOTE_NUM +: VOTE_NUM] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  // ---------------- drivers ----------------
  initial begin
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_pixel(input logic [SW-1:0] d, input logic tu, input logic tl);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      #1;
      s_tdata  = d;
      s_tuser  = tu;
      s_tlast  = tl;
      s_tvalid = 1'b1;
      done     = s_tready;
      @(posedge clk);
      guard++;
    end
    if (!done) check("accept_timeout", 32'(guard), 0);
    else exp_q.push_back(model(d, tu, tl, param_th));
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    #1;
    s_tvalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("drain", 32'(exp_q.size()), 0);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_cur = {m_tuser, m_tlast, m_tclass, m_tcount, m_tdetect};
      if (mon_stall && !reset) check("stable_when_stalled", 32'(mon_cur), 32'(mon_prev));
      if (m_tvalid && m_tready) begin
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 32'(exp_q.size()), 1);
        else check("out", 32'(mon_cur), 32'(exp_q.pop_front()));
      end
      mon_stall = m_tvalid && !m_tready && !reset;
      mon_prev  = mon_cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int n0;
    logic [SW-1:0] d;
    param_th = 4'd5;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 32'(s_tready), 1);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle_m_tvalid", 32'(m_tvalid), 0);
    check("idle_s_tready", 32'(s_tready), 1);
    check("idle_fields", 32'({m_tuser, m_tlast, m_tclass, m_tcount, m_tdetect}), 0);
    check("idle_stat", 32'(stat), 0);

    // Basic argmax and latency: three rising edges counting the accept edge.
    param_th = 4'd5;
    drive_pixel(votes2(3, 8'hFF, 7, 8'h0F), 1'b0, 1'b0);
    n = 1;
    while (n < 10) begin
      @(negedge clk);
      if (m_tvalid) break;
      @(posedge clk);
      n++;
    end
    check("latency", 32'(n), 3);
    check("basic_class", 32'(m_tclass), 3);
    check("basic_count", 32'(m_tcount), 8);
    check("basic_detect", 32'(m_tdetect), 1);
    drain();

    // Tie between classes 2 and 5, below then at threshold.
    param_th = 4'd7;
    drive_pixel(votes2(2, 8'h3F, 5, 8'h3F), 1'b0, 1'b0);
    drain();
    param_th = 4'd6;
    drive_pixel(votes2(2, 8'h3F, 5, 8'h3F), 1'b0, 1'b0);
    drain();

    // Threshold boundaries: 0 detects even an all-zero pixel; above VOTE_NUM
    // never detects. All-full pixel ties at class 0.
    param_th = 4'd0;
    drive_pixel('0, 1'b0, 1'b0);
    drain();
    param_th = 4'd9;
    drive_pixel(votes2(9, 8'hFF, 4, 8'h7F), 1'b0, 1'b0);
    drive_pixel('1, 1'b0, 1'b0);
    drain();
    param_th = 4'd15;
    drive_pixel('1, 1'b0, 1'b0);
    drain();

    // Back-to-back random burst at full rate.
    param_th = 4'd5;
    for (int i = 0; i < 8; i++) drive_pixel(rand_votes(), 1'b0, 1'b0);
    drain();

    // 20-pixel line under 50% random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) drive_pixel(rand_votes(), (i == 0), (i == 19));
    drain();
    rand_ready = 1'b0;
    @(negedge clk);

    // Bubbles between two pixels.
    n0 = n_out;
    drive_pixel(votes2(1, 8'h03, 6, 8'h07), 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    drive_pixel(votes2(8, 8'hFF, 0, 8'h01), 1'b0, 1'b1);
    drain();
    check("bubble_count", 32'(n_out - n0), 2);

    // Asynchronous reset with pixels in flight.
    drive_pixel(votes2(4, 8'hFF, 0, 8'h00), 1'b0, 1'b0);
    drive_pixel(votes2(5, 8'hFF, 0, 8'h00), 1'b0, 1'b0);
    drive_pixel(votes2(6, 8'hFF, 0, 8'h00), 1'b0, 1'b0);
    check("pre_rst_valid", 32'(m_tvalid), 1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(m_tvalid), 0);
    check("async_rst_tready", 32'(s_tready), 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_pixel(votes2(2, 8'h0F, 9, 8'h1F), 1'b0, 1'b0);
    drain();

    // Frame of 16 pixels, 5 detected, then next frame start.
    param_th = 4'd5;
    for (int i = 0; i < 16; i++) begin
      d = ((i % 3) == 1) ? votes2(0, 8'hFF, 1, 8'h00) : '0;
      drive_pixel(d, (i == 0), 1'b0);
    end
    drive_pixel('0, 1'b1, 1'b0);
    drain();
`ifdef VIDEO_MNIST_CNN_ARGMAX_STAT_EN
    check("stat_frame", 32'(stat), 5);
`else
    check("stat_tied", 32'(stat), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/video_mnist_cnn_argmax.md
Name: video_mnist_cnn_argmax

Overview:
- Stage directly downstream of the MNIST CNN detection core.
- Consumes the core's per-pixel class-vote stream: NUM_CLASS groups of VOTE_NUM binary votes, at 1/4 resolution.
- Pipelined: per-class popcount, argmax, threshold test.
- Emits per pixel: class index, winning vote count and a detect flag, for the overlay/drawing stage.

Parameters:
- TUSER_WIDTH, 1, sideband width, passed through unchanged.
- NUM_CLASS, 10, number of classes.
- VOTE_NUM, 8, votes per class.
- S_TDATA_WIDTH, NUM_CLASS*VOTE_NUM, input width. Class c occupies bits [c*VOTE_NUM +: VOTE_NUM].
- CLASS_WIDTH, 4, class index width; must satisfy 2^CLASS_WIDTH >= NUM_CLASS.
- COUNT_WIDTH, 4, vote count width; must satisfy 2^COUNT_WIDTH > VOTE_NUM.
- STAT_WIDTH, 20, per-frame detect counter width.

Ports:
- reset  in  1  asynchronous active-high reset.
- clk  in  1  clock.
- param_th  in  COUNT_WIDTH  detect threshold on winning count.
- s_axi4s_tuser  in  TUSER_WIDTH  bit0 = frame start.
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tdata  in  S_TDATA_WIDTH  class votes.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser.
- m_axi4s_tlast  out  1  delayed tlast.
- m_axi4s_tclass  out  CLASS_WIDTH  argmax class.
- m_axi4s_tcount  out  COUNT_WIDTH  winning vote count.
- m_axi4s_tdetect  out  1  tcount >= param_th.
- m_axi4s_tvalid  out  1  output valid.
- m_axi4s_tready  in  1  output ready.
- stat_detect_count  out  STAT_WIDTH  detected pixels in the last complete frame.

Behaviour:
- Single clock `clk`; reset is asynchronous and active-high (`reset`).
- Three-stage pipeline, all stages enabled by cke = ~m_axi4s_tvalid | m_axi4s_tready.
- s_axi4s_tready = cke, combinational from m_axi4s_tready and internal valid only, with no dependence on s_axi4s_tvalid.
- Stage valid bits advance on cke. A bubble (tvalid=0) propagates as valid=0.
- Stage 1: register popcount of each class group (0..VOTE_NUM), tuser, tlast, valid.
- Stage 2: argmax over classes 0..NUM_CLASS-1.
  - Strictly-greater comparison, so on ties the lowest index wins.
  - All counts zero gives class 0, count 0.
- Stage 3: register class and count. detect = (count >= param_th), where param_th is sampled at this stage.
  - param_th = 0 makes every valid pixel detected.
  - param_th > VOTE_NUM makes no pixel detected.
- Latency: exactly 3 clk from input accept to output valid when m_axi4s_tready is held high. Throughput is 1 pixel/clk.
- Backpressure:
  - While m_axi4s_tvalid=1 and m_axi4s_tready=0, all outputs hold stable and s_axi4s_tready=0.
  - No data is lost or duplicated.
- m_axi4s_tuser and m_axi4s_tlast are aligned with their pixel. No other reordering.
- Reset values: all stage valids 0, m_axi4s_tvalid 0, tuser/tlast/tclass/tcount/tdetect 0, stat_detect_count 0.
  - s_axi4s_tready = 1 during and after reset (pipeline empty).
- Reset mid-frame: in-flight pixels are discarded and the stat accumulator is cleared. No partial output is emitted after reset deassertion.

Optional Feature:
- Macro: VIDEO_MNIST_CNN_ARGMAX_STAT_EN.
- Defined:
  - A detect accumulator increments on each output handshake (m_axi4s_tvalid & m_axi4s_tready & m_axi4s_tdetect). It saturates at all-ones.
  - On an output handshake with m_axi4s_tuser[0]=1, the accumulator value from before that pixel is copied to stat_detect_count. The accumulator restarts at 0, or at 1 if that pixel is itself detected.
- Not defined: stat_detect_count is tied to 0 and no accumulator logic exists.

Decomposition:
- Package video_mnist_cnn_pkg holds:
  - NUM_CLASS and VOTE_NUM defaults.
  - CLASS_WIDTH and COUNT_WIDTH localparams.
  - Class index and vote count typedefs.
- One sub-module: video_mnist_cnn_popcount. It is a parameterised registered popcount of one VOTE_NUM group, instantiated NUM_CLASS times in stage 1.

Test Plan:
- Basic argmax: votes class 3 = 8'hFF, class 7 = 8'h0F, others 0; param_th=5; tready=1 -> after 3 clk: tclass=3, tcount=8, tdetect=1.
- Tie and threshold: class 2 and class 5 both 8'h3F, param_th=7 -> tclass=2, tcount=6, tdetect=0; repeat with param_th=6 -> tdetect=1.
- Backpressure: 20-pixel stream with random tready (50%) -> output sequence identical to the tready=1 run; tlast on pixel 19 only; outputs stable while stalled.
- Bubbles: tvalid toggling 1,0,0,1 -> exactly 2 outputs, correct order, no spurious valid.
- Reset mid-stream: assert reset with 2 pixels in flight -> tvalid=0 immediately (async); after release, the first output is the first pixel accepted after reset.
- STAT_EN: frame of 16 pixels with 5 detected, then tuser[0]=1 on the next frame's first pixel -> stat_detect_count=5 on that handshake; without the macro it stays 0.
